// File: rtl/fir_pkg.sv
// Shared fixed-point definitions for the FM demod FIR path: Q(BITS) scaling,
// default low-pass coefficients, FSM state encoding and the (de)quantizers
// also used by the upstream I*Q product multiplier.
package fir_pkg;

  localparam int BITS      = 10;
  localparam int QUANT_VAL = 1 << BITS;
  localparam int FIR_DW    = 32;
  localparam int FIR_PW    = 2 * FIR_DW;
  localparam int FIR_TAPS  = 32;

  // Symmetric windowed-sinc low-pass, Q10.
  localparam logic signed [FIR_DW-1:0] FIR_COEFS [FIR_TAPS] = '{
    -1, -2, -3, -4, -3, 0, 7, 17, 30, 46, 63, 79, 93, 103, 109, 111,
    111, 109, 103, 93, 79, 63, 46, 30, 17, 7, 0, -3, -4, -3, -2, -1
  };

  typedef logic [1:0] state_t;
  localparam state_t S_LOAD = 2'd0;
  localparam state_t S_MAC  = 2'd1;
  localparam state_t S_OUT  = 2'd2;

  function automatic logic signed [FIR_DW-1:0] QUANTIZE(input logic signed [FIR_DW-1:0] x);
    return x <<< BITS;
  endfunction

  // Arithmetic shift that rounds toward zero: negative values are biased
  // by 2^BITS-1 first so the floor of the shift lands on the truncated value.
  function automatic logic signed [FIR_PW-1:0] DEQUANTIZE(input logic signed [FIR_PW-1:0] x);
    logic signed [FIR_PW-1:0] biased;
    biased = x;
    if (x < 0) biased = x + FIR_PW'(QUANT_VAL - 1);
    return biased >>> BITS;
  endfunction

endpackage

// File: rtl/fir_decim_if.sv
// FIFO-side signals of the decimating FIR: pop side of the upstream FIFO and
// push side of the downstream FIFO. master = filter, slave = FIFO environment.
interface fir_decim_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic signed [DATA_WIDTH-1:0] in_dout;
  logic                         in_empty;
  logic                         in_rd_en;
  logic signed [DATA_WIDTH-1:0] out_din;
  logic                         out_full;
  logic                         out_wr_en;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en
  );

endinterface

// File: rtl/fir_mac.sv
// Single multiply-accumulate slice: full-width product, dequantize, then
// accumulate. Accumulation wraps by default; defining FIR_DECIM_SATURATE_EN
// makes every accumulate step clamp to the signed DATA_WIDTH range.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] coef,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0] acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         term;
  logic signed [PW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] acc_nxt;

`ifdef FIR_DECIM_SATURATE_EN
  function automatic logic signed [DATA_WIDTH-1:0] acc_step(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = PW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    lo = -hi - PW'(1);
    if (x > hi)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (x < lo) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else             return x[DATA_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [DATA_WIDTH-1:0] acc_step(input logic signed [PW-1:0] x);
    return x[DATA_WIDTH-1:0];
  endfunction
`endif

  // Product at double width, dequantized, added to the sign-extended accumulator.
  always_comb begin
    prod    = PW'(coef) * PW'(sample);
    term    = PW'(DEQUANTIZE(FIR_PW'(prod)));
    sum     = PW'(acc) + term;
    acc_nxt = acc_step(sum);
  end

  // Accumulator register: clear starts a new output, en adds one tap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc_nxt;
  end

endmodule

// File: rtl/fir_decim.sv
// Decimating low-pass FIR: shifts DECIM samples into a TAPS-deep history,
// then runs TAPS sequential MAC cycles and pushes one filtered sample.
// Optional FIR_DECIM_SATURATE_EN selects saturating accumulation in fir_mac.
module fir_decim
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter logic signed [DATA_WIDTH-1:0] COEFS [TAPS] = FIR_COEFS
) (
  input logic       clock,
  input logic       reset,
  fir_decim_if.master bus
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic signed [DATA_WIDTH-1:0] sbuf [TAPS];
  logic signed [DATA_WIDTH-1:0] acc;
  logic                         pop;
  logic                         push;
  logic                         group_done;
  logic signed [DATA_WIDTH-1:0] dout;

  // Handshake outputs decode registered state only; held low while in reset.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    dout = '0;
    if (reset) begin
      case (state)
        S_LOAD: pop = !bus.in_empty;
        S_OUT: begin
          if (!bus.out_full) begin
            push = 1'b1;
            dout = acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign group_done    = pop && (cnt == CNT_W'(DECIM - 1));
  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.out_din   = dout;

  // Control FSM: load DECIM samples, walk TAPS taps, then wait to push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_LOAD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (group_done) begin
            cnt   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end else if (pop) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_MAC: begin
          if (idx == IDX_W'(TAPS - 1)) state <= S_OUT;
          else                         idx   <= idx + IDX_W'(1);
        end
        S_OUT: begin
          if (push) state <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Sample history: newest in sbuf[0], oldest falls off the end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) sbuf[k] <= '0;
    end else if (pop) begin
      sbuf[0] <= bus.in_dout;
      for (int k = 1; k < TAPS; k++) sbuf[k] <= sbuf[k-1];
    end
  end

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (group_done),
    .en     (state == S_MAC),
    .coef   (COEFS[idx]),
    .sample (sbuf[idx]),
    .acc    (acc)
  );

endmodule
